// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, FSM states and
// instruction field positions derived from the datapath parameters.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_ADDI = 4'd8,
        OP_LD   = 4'd9,
        OP_ST   = 4'd10,
        OP_BEQ  = 4'd11,
        OP_JMP  = 4'd12,
        OP_LDI  = 4'd13,
        OP_RSVD = 4'd14,
        OP_HALT = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // Instruction layout, MSB first: opcode, rd, rs1, rs2, imm.
    function automatic int instr_width(int dw, int rb);
        return 4 + 3 * rb + dw;
    endfunction

    function automatic int opcode_lsb(int dw, int rb);
        return dw + 3 * rb;
    endfunction

    function automatic int rd_lsb(int dw, int rb);
        return dw + 2 * rb;
    endfunction

    function automatic int rs1_lsb(int dw, int rb);
        return dw + rb;
    endfunction

    function automatic int rs2_lsb(int dw);
        return dw;
    endfunction

    // ALU-class opcodes: the only ones that touch the flags.
    function automatic logic updates_flags(opcode_t op);
        return (op >= OP_ADD) && (op <= OP_ADDI);
    endfunction

    function automatic logic writes_rd(opcode_t op);
        return updates_flags(op) || (op == OP_LD) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two asynchronous operand reads, one debug read,
// one synchronous write, cleared synchronously on reset.
module cpu_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_BITS-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [REG_BITS-1:0]   raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [REG_BITS-1:0]   raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    input  logic [REG_BITS-1:0]   dbg_sel,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int unsigned NREGS = 2 ** REG_BITS;

    logic [DATA_WIDTH-1:0] regs [NREGS];

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_sel];

    // Register write port with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle CPU core: program-loadable instruction memory, PC with
// branch/jump, flags, private data memory and a FETCH/DECODE/EXEC/MEM/WB FSM.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int REG_BITS   = 2,
    parameter int PC_BITS    = 6,
    localparam int INSTR_WIDTH = 4 + 3 * REG_BITS + DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic                   busy,
    output logic                   halted,
    output logic [PC_BITS-1:0]     pc,
    output logic                   flag_zero,
    output logic                   flag_carry,
    input  logic [REG_BITS-1:0]    dbg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_data
);

    localparam int OP_LSB  = opcode_lsb(DATA_WIDTH, REG_BITS);
    localparam int RD_LSB  = rd_lsb(DATA_WIDTH, REG_BITS);
    localparam int RS1_LSB = rs1_lsb(DATA_WIDTH, REG_BITS);
    localparam int RS2_LSB = rs2_lsb(DATA_WIDTH);

    state_t state, next_state;

    logic [INSTR_WIDTH-1:0] imem [2 ** PC_BITS];
    logic [DATA_WIDTH-1:0]  dmem [2 ** ADDR_BITS];

    logic [INSTR_WIDTH-1:0] ir;
    opcode_t                op;
    logic [REG_BITS-1:0]    rd, rs1, rs2;
    logic [DATA_WIDTH-1:0]  imm;

    logic [DATA_WIDTH-1:0]  rs1_val, rs2_val;
    logic [DATA_WIDTH-1:0]  opa, opb;
    logic [DATA_WIDTH-1:0]  res;
    logic [DATA_WIDTH-1:0]  alu_res;
    logic                   alu_carry;
    logic [ADDR_BITS-1:0]   mem_addr;
    logic [PC_BITS-1:0]     pc_next;
    logic [PC_BITS-1:0]     imm_pc;
    logic                   rf_we;

    assign op  = opcode_t'(ir[OP_LSB +: 4]);
    assign rd  = ir[RD_LSB +: REG_BITS];
    assign rs1 = ir[RS1_LSB +: REG_BITS];
    assign rs2 = ir[RS2_LSB +: REG_BITS];
    assign imm = ir[DATA_WIDTH-1:0];

    // Branch offset is two's complement; sign-extend or truncate to PC width.
    assign imm_pc = PC_BITS'($signed(imm));

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);
    assign rf_we  = (state == S_WB) && writes_rd(op);

    cpu_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_BITS  (REG_BITS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (res),
        .raddr_a (rs1),
        .rdata_a (rs1_val),
        .raddr_b (rs2),
        .rdata_b (rs2_val),
        .dbg_sel (dbg_sel),
        .dbg_data(dbg_data)
    );

    // ALU: result and carry/borrow for the instruction held in EXEC.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD:  {alu_carry, alu_res} = {1'b0, opa} + {1'b0, opb};
            OP_SUB:  {alu_carry, alu_res} = {1'b0, opa} - {1'b0, opb};
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SHL:  alu_res = opa << 1;
            OP_SHR:  alu_res = opa >> 1;
            OP_ADDI: {alu_carry, alu_res} = {1'b0, opa} + {1'b0, imm};
            OP_LDI:  alu_res = imm;
            default: alu_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_HALT: if (start) next_state = S_FETCH;
            S_FETCH:        next_state = S_DECODE;
            S_DECODE:       next_state = S_EXEC;
            S_EXEC: begin
                if ((op == OP_LD) || (op == OP_ST)) begin
                    next_state = S_MEM;
                end else if (op == OP_HALT) begin
                    next_state = S_HALT;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM:          next_state = S_WB;
            S_WB:           next_state = S_FETCH;
            default:        next_state = S_IDLE;
        endcase
    end

    // Datapath registers: PC, IR, operands, result, flags, branch target.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            ir         <= '0;
            opa        <= '0;
            opb        <= '0;
            res        <= '0;
            mem_addr   <= '0;
            pc_next    <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: if (start) pc <= '0;
                S_FETCH:        ir <= imem[pc];
                S_DECODE: begin
                    opa <= rs1_val;
                    opb <= rs2_val;
                end
                S_EXEC: begin
                    res      <= alu_res;
                    mem_addr <= ADDR_BITS'(opa + imm);
                    case (op)
                        OP_BEQ:  pc_next <= (opa == opb) ? (pc + PC_BITS'(1) + imm_pc)
                                                         : (pc + PC_BITS'(1));
                        OP_JMP:  pc_next <= PC_BITS'(imm);
                        default: pc_next <= pc + PC_BITS'(1);
                    endcase
                    if (updates_flags(op)) begin
                        flag_zero  <= (alu_res == '0);
                        flag_carry <= alu_carry;
                    end
                end
                S_MEM:   if (op == OP_LD) res <= dmem[mem_addr];
                S_WB:    pc <= pc_next;
                default: ;
            endcase
        end
    end

    // Program load port, accepted only while the core is idle or halted.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            imem[prog_addr] <= prog_data;
        end
    end

    // Data memory store, performed in the MEM state of an ST.
    always_ff @(posedge clk) begin
        if ((state == S_MEM) && (op == OP_ST)) begin
            dmem[mem_addr] <= opb;
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: an instruction-level interpreter
// predicts final state and cycle counts; a monitor checks on halt/snapshot.
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [17:0] prog_data;
    logic        busy;
    logic        halted;
    logic [5:0]  pc;
    logic        flag_zero;
    logic        flag_carry;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    always #5 clk = ~clk;

    multicycle_cpu #(
        .DATA_WIDTH(8),
        .ADDR_BITS (5),
        .REG_BITS  (2),
        .PC_BITS   (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc),
        .flag_zero (flag_zero),
        .flag_carry(flag_carry),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    typedef struct packed {
        logic            is_halt;
        logic [31:0]     cycles;
        logic            busy;
        logic            halted;
        logic [5:0]      pc;
        logic            fz;
        logic            fc;
        logic [3:0][7:0] regs;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_mis    = 0;
    int   mon_done = 0;
    int   snap_cnt = 0;

    // Reference machine state
    logic [17:0] m_imem [64];
    int          m_reg  [4];
    int          m_dmem [32];
    int          m_fz, m_fc;
    logic [17:0] prog   [64];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [17:0] enc(int op, int rd, int rs1, int rs2, int imm);
        logic [17:0] w;
        w = {op[3:0], rd[1:0], rs1[1:0], rs2[1:0], imm[7:0]};
        return w;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 4; r++) m_reg[r] = 0;
        m_fz = 0;
        m_fc = 0;
    endfunction

    function automatic void setf(int rd, int full, int carry);
        m_fc      = carry;
        m_reg[rd] = full & 255;
        m_fz      = (m_reg[rd] == 0) ? 1 : 0;
    endfunction

    // Instruction-level interpreter: runs from address 0 until HALT.
    function automatic exp_t model_run();
        exp_t e;
        int   p, cyc, steps, op, rd, rs1, rs2, imm, a, b, npc, simm;
        bit   stop;
        logic [17:0] w;
        p = 0; cyc = 0; steps = 0; stop = 0;
        while (!stop && steps < 4000) begin
            w    = m_imem[p];
            op   = int'(w[17:14]);
            rd   = int'(w[13:12]);
            rs1  = int'(w[11:10]);
            rs2  = int'(w[9:8]);
            imm  = int'(w[7:0]);
            a    = m_reg[rs1];
            b    = m_reg[rs2];
            npc  = (p + 1) % 64;
            steps++;
            cyc += (op == 9 || op == 10) ? 5 : ((op == 15) ? 3 : 4);
            case (op)
                1:  setf(rd, a + b, (a + b > 255) ? 1 : 0);
                2:  setf(rd, a - b, (a < b) ? 1 : 0);
                3:  setf(rd, a & b, 0);
                4:  setf(rd, a | b, 0);
                5:  setf(rd, a ^ b, 0);
                6:  setf(rd, a * 2, 0);
                7:  setf(rd, a / 2, 0);
                8:  setf(rd, a + imm, (a + imm > 255) ? 1 : 0);
                9:  m_reg[rd] = m_dmem[(a + imm) % 32];
                10: m_dmem[(a + imm) % 32] = b;
                11: begin
                    simm = (imm > 127) ? imm - 256 : imm;
                    if (a == b) npc = (((p + 1 + simm) % 64) + 64) % 64;
                end
                12: npc = imm % 64;
                13: m_reg[rd] = imm;
                15: stop = 1;
                default: ;
            endcase
            if (!stop) p = npc;
        end
        e.is_halt = 1'b1;
        e.cycles  = 32'(cyc);
        e.busy    = 1'b0;
        e.halted  = 1'b1;
        e.pc      = 6'(p);
        e.fz      = 1'(m_fz);
        e.fc      = 1'(m_fc);
        for (int r = 0; r < 4; r++) e.regs[r] = 8'(m_reg[r]);
        return e;
    endfunction

    // Monitor: pops one expectation per halt entry or snapshot request.
    initial begin : monitor
        exp_t e;
        int   seen, busy_cyc, n_pop;
        logic prev_h;
        seen = 0; busy_cyc = 0; prev_h = 1'b0;
        dbg_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (busy) busy_cyc++;
            else if (!halted) busy_cyc = 0;
            n_pop = 0;
            if (halted && !prev_h) n_pop++;
            prev_h = halted;
            if (snap_cnt != seen) begin
                n_pop++;
                seen = snap_cnt;
            end
            for (int k = 0; k < n_pop; k++) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("busy", busy, e.busy);
                    check("halted", halted, e.halted);
                    check("pc", pc, e.pc);
                    check("flag_zero", flag_zero, e.fz);
                    check("flag_carry", flag_carry, e.fc);
                    if (e.is_halt) begin
                        check("cycles", busy_cyc, e.cycles);
                        busy_cyc = 0;
                    end
                    for (int r = 0; r < 4; r++) begin
                        dbg_sel = 2'(r);
                        #1;
                        check($sformatf("reg%0d", r), dbg_data, e.regs[r]);
                    end
                end
                mon_done++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (mon_done < target && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (mon_done < target) begin
            check("timeout", 32'(mon_done), 32'(target));
            sb.delete();
            do_reset();
        end
    endtask

    task automatic snapshot();
        exp_t e;
        int   tgt;
        e.is_halt = 1'b0;
        e.cycles  = '0;
        e.busy    = 1'b0;
        e.halted  = 1'b0;
        e.pc      = 6'd0;
        e.fz      = 1'(m_fz);
        e.fc      = 1'(m_fc);
        for (int r = 0; r < 4; r++) e.regs[r] = 8'(m_reg[r]);
        sb.push_back(e);
        tgt = mon_done + 1;
        snap_cnt++;
        wait_done(tgt);
    endtask

    task automatic load_prog();
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 6'(a);
            prog_data = prog[a];
            m_imem[a] = prog[a];
        end
        @(negedge clk) prog_we = 1'b0;
    endtask

    task automatic clear_prog();
        for (int a = 0; a < 64; a++) prog[a] = enc(15, 0, 0, 0, 0);
    endtask

    task automatic run_and_wait();
        int tgt;
        sb.push_back(model_run());
        tgt = mon_done + 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(tgt);
    endtask

    initial begin : stimulus
        int tgt, len, op, hi;
        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        for (int a = 0; a < 32; a++) m_dmem[a] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        snapshot();

        // Zero the data memory so later loads are deterministic
        clear_prog();
        for (int a = 0; a < 32; a++) prog[a] = enc(10, 0, 0, 0, a);
        load_prog();
        run_and_wait();

        // LDI/LDI/ADD/HALT
        clear_prog();
        prog[0] = enc(13, 1, 0, 0, 5);
        prog[1] = enc(13, 2, 0, 0, 3);
        prog[2] = enc(1, 3, 1, 2, 0);
        load_prog();
        run_and_wait();

        // ADDI wrap to zero with carry
        clear_prog();
        prog[0] = enc(13, 1, 0, 0, 8'hFF);
        prog[1] = enc(8, 2, 1, 0, 1);
        load_prog();
        run_and_wait();

        // SUB 3-5 borrows
        clear_prog();
        prog[0] = enc(13, 1, 0, 0, 3);
        prog[1] = enc(13, 2, 0, 0, 5);
        prog[2] = enc(2, 3, 1, 2, 0);
        load_prog();
        run_and_wait();

        // Store then load through rs1+imm
        clear_prog();
        prog[0] = enc(13, 1, 0, 0, 4);
        prog[1] = enc(13, 2, 0, 0, 8'hAA);
        prog[2] = enc(10, 0, 1, 2, 2);
        prog[3] = enc(9, 3, 1, 0, 2);
        load_prog();
        run_and_wait();

        // Countdown loop with backward JMP and BEQ exit
        clear_prog();
        prog[0] = enc(13, 1, 0, 0, 3);
        prog[1] = enc(13, 2, 0, 0, 1);
        prog[2] = enc(2, 1, 1, 2, 0);
        prog[3] = enc(11, 0, 1, 0, 1);
        prog[4] = enc(12, 0, 0, 0, 2);
        load_prog();
        run_and_wait();

        // Negative BEQ offset: 5+1-5 lands on HALT at 1
        clear_prog();
        prog[0] = enc(12, 0, 0, 0, 4);
        prog[4] = enc(13, 1, 0, 0, 9);
        prog[5] = enc(11, 0, 0, 0, 8'hFB);
        load_prog();
        run_and_wait();

        // Reset during the EXEC of the ADD: write must be dropped
        clear_prog();
        prog[0] = enc(13, 1, 0, 0, 5);
        prog[1] = enc(13, 2, 0, 0, 3);
        prog[2] = enc(1, 3, 1, 2, 0);
        load_prog();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        model_reset();
        snapshot();
        run_and_wait();

        // prog_we while busy must be ignored
        clear_prog();
        prog[0] = enc(13, 1, 0, 0, 8'h11);
        prog[1] = enc(13, 2, 0, 0, 8'h22);
        load_prog();
        sb.push_back(model_run());
        tgt = mon_done + 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 6'd1; prog_data = enc(13, 2, 0, 0, 8'h77);
        @(negedge clk) prog_we = 1'b0;
        wait_done(tgt);
        run_and_wait();

        // prog_we together with start lands before the first fetch
        m_imem[1] = enc(13, 2, 0, 0, 8'h77);
        sb.push_back(model_run());
        tgt = mon_done + 1;
        @(negedge clk);
        start = 1'b1; prog_we = 1'b1; prog_addr = 6'd1; prog_data = enc(13, 2, 0, 0, 8'h77);
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        wait_done(tgt);

        // Random forward-only programs
        for (int t = 0; t < 15; t++) begin
            clear_prog();
            len = $urandom_range(4, 24);
            for (int i = 0; i < len; i++) begin
                op = $urandom_range(0, 14);
                if (op == 11) begin
                    prog[i] = enc(op, 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6));
                end else if (op == 12) begin
                    hi = i + 1;
                    prog[i] = enc(op, 0, 0, 0, $urandom_range(hi, 63));
                end else begin
                    prog[i] = enc(op, $urandom_range(0, 3), $urandom_range(0, 3),
                                  $urandom_range(0, 3), $urandom_range(0, 255));
                end
            end
            load_prog();
            run_and_wait();
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
